level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
Parametrised level/difficulty controller for the block-stacker game. It tracks the current level and derives two values for the datapath: the per-level move period (speed_count) and the width of the moving block row (num_blocks). It advances the level on a successful placement, ends the game on a miss, and restarts on a go press. It sits between the input/placement-check logic and the row-animation datapath.

Parameters:
NUM_LEVELS, 15, number of levels; winning level NUM_LEVELS ends the game in WIN.
LEVEL_W, 6, width of curr_level; must hold NUM_LEVELS.
SPEED_W, 11, width of speed_count.
BASE_SPEED, 60, speed_count at level 1, in frames per move.
SPEED_STEP, 4, speed_count decrement per level.
MIN_SPEED, 8, floor for speed_count.
BLK_W, 4, width of num_blocks and place_overlap.
START_BLOCKS, 3, num_blocks at level 1.
SHRINK_EVERY, 5, number of levels cleared per scheduled num_blocks decrement.
CARRY_OVERLAP, 0, when 1, num_blocks after a hit = min(schedule value, place_overlap).

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
go  in  1  start/restart button, level-sensitive; internally edge-detected
place_valid  in  1  one-cycle pulse: placement result for the current row is valid
place_hit  in  1  qualified by place_valid; 1 = row landed on the stack
place_overlap  in  BLK_W  qualified by place_valid; number of blocks that overlapped
speed_count  out  SPEED_W  frames per move for the current level
num_blocks  out  BLK_W  row width for the current level
curr_level  out  LEVEL_W  current level, 1-based
playing  out  1  high in RUN
level_up  out  1  one-cycle pulse on a level advance
game_won  out  1  high in WIN
game_over  out  1  high in OVER

Behaviour:
- All outputs are registered. Reset (resetn=0 at a clk edge) sets state=WAIT, curr_level=1, speed_count=BASE_SPEED, num_blocks=START_BLOCKS, shrink counter=0, and clears level_up, playing, game_won and game_over. go_prev is set to 1, so a button held through reset does not start a game.
- go_rise = go & ~go_prev; go_prev is registered every cycle.
- States:
  - WAIT: go_rise -> RUN.
  - RUN: place_valid & effective_hit -> advance; place_valid & ~effective_hit -> OVER; otherwise stay in RUN.
  - WIN / OVER: go_rise -> load level-1 values (same values as reset) -> WAIT.
- effective_hit = place_hit, and additionally place_overlap != 0 when CARRY_OVERLAP=1.
- place_valid is ignored outside RUN.
- Advance, when curr_level == NUM_LEVELS: go to WIN; level_up=0; curr_level, speed_count and num_blocks hold.
- Advance, otherwise (all updated on the same edge):
  - curr_level += 1.
  - speed_count = (speed_count - SPEED_STEP) if that result is >= MIN_SPEED, else MIN_SPEED; saturating, no underflow wrap.
  - Shrink counter += 1. When it reaches SHRINK_EVERY, it resets to 0 and the schedule value decrements, floored at 1. No divider is used.
  - num_blocks = schedule value; with CARRY_OVERLAP=1 it is min(schedule value, place_overlap).
  - level_up = 1 for exactly one cycle; next state is WAIT.
- Latency: outputs take their new values on the clk edge after the place_valid cycle; there are no combinational paths from inputs to outputs.
- Simultaneous events:
  - go_rise in RUN is ignored.
  - place_valid in the same cycle as a WAIT->RUN transition is ignored.
  - Reset takes priority over every other event.
- Reset mid-game, from any state, returns to level-1 values in WAIT on the next edge.

Test Plan:
1. Reset with go held high, then keep go high -> state stays WAIT, curr_level=1, speed_count=60, num_blocks=3; a release then press -> playing=1 one cycle after the go rising edge.
2. Play 14 consecutive hits (go press between each level) -> speed_count sequence 60,56,...,12,8,8; num_blocks=3 for levels 1-5, 2 for 6-10, 1 for 11-15; one level_up pulse per advance.
3. At level 15, hit -> game_won=1, level_up stays 0, curr_level=15; then go press -> curr_level=1, speed_count=60, num_blocks=3, state WAIT.
4. At level 4, place_valid with place_hit=0 -> game_over=1, playing=0; a further place_valid is ignored; go press -> level-1 values.
5. CARRY_OVERLAP=1, level 1: hit with place_overlap=2 -> num_blocks=2. At level 2, hit=1 with overlap=0 -> game_over=1.
6. Assert resetn=0 for one cycle in RUN at level 7 -> next edge gives curr_level=1, speed_count=60, num_blocks=3, all flags 0. Also verify that a place_valid arriving in the same cycle as the go edge in WAIT is ignored.

Source files
------------

// File: rtl/level_sequencer.sv
// Level/difficulty controller for the block-stacker game: tracks the level and
// derives the per-level move period and moving-row width for the datapath.
module level_sequencer #(
    parameter int NUM_LEVELS    = 15,
    parameter int LEVEL_W       = 6,
    parameter int SPEED_W       = 11,
    parameter int BASE_SPEED    = 60,
    parameter int SPEED_STEP    = 4,
    parameter int MIN_SPEED     = 8,
    parameter int BLK_W         = 4,
    parameter int START_BLOCKS  = 3,
    parameter int SHRINK_EVERY  = 5,
    parameter int CARRY_OVERLAP = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               place_valid,
    input  logic               place_hit,
    input  logic [BLK_W-1:0]   place_overlap,
    output logic [SPEED_W-1:0] speed_count,
    output logic [BLK_W-1:0]   num_blocks,
    output logic [LEVEL_W-1:0] curr_level,
    output logic               playing,
    output logic               level_up,
    output logic               game_won,
    output logic               game_over
);

    localparam int SHR_W = $clog2(SHRINK_EVERY + 1);

    localparam logic [LEVEL_W-1:0] LEVEL_FIRST = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(NUM_LEVELS);
    localparam logic [SPEED_W-1:0] SPEED_INIT  = SPEED_W'(BASE_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_STEPV = SPEED_W'(SPEED_STEP);
    localparam logic [SPEED_W-1:0] SPEED_MIN   = SPEED_W'(MIN_SPEED);
    // Below this value one more step would undershoot the floor.
    localparam logic [SPEED_W-1:0] SPEED_SAFE  = SPEED_W'(MIN_SPEED + SPEED_STEP);
    localparam logic [BLK_W-1:0]   BLK_INIT    = BLK_W'(START_BLOCKS);
    localparam logic [BLK_W-1:0]   BLK_ONE     = BLK_W'(1);
    localparam logic [SHR_W-1:0]   SHR_LAST    = SHR_W'(SHRINK_EVERY);

    typedef enum logic [1:0] {
        WAIT,
        RUN,
        WIN,
        OVER
    } state_t;

    state_t             state_reg, state_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [SPEED_W-1:0] speed_reg, speed_next;
    logic [BLK_W-1:0]   blocks_reg, blocks_next;
    logic [BLK_W-1:0]   sched_reg, sched_next;
    logic [SHR_W-1:0]   shrink_reg, shrink_next;
    logic [SHR_W-1:0]   shrink_inc;
    logic               level_up_reg, level_up_next;
    logic               go_prev_reg;
    logic               playing_reg;
    logic               won_reg;
    logic               over_reg;
    logic               go_rise;
    logic               effective_hit;

    assign go_rise       = go & ~go_prev_reg;
    assign effective_hit = place_hit && ((CARRY_OVERLAP == 0) || (place_overlap != '0));
    assign shrink_inc    = shrink_reg + SHR_W'(1);

    always_comb begin
        state_next    = state_reg;
        level_next    = level_reg;
        speed_next    = speed_reg;
        blocks_next   = blocks_reg;
        sched_next    = sched_reg;
        shrink_next   = shrink_reg;
        level_up_next = 1'b0;

        case (state_reg)
            WAIT: begin
                if (go_rise) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (place_valid) begin
                    if (!effective_hit) begin
                        state_next = OVER;
                    end else if (level_reg == LEVEL_LAST) begin
                        state_next = WIN;
                    end else begin
                        state_next    = WAIT;
                        level_up_next = 1'b1;
                        level_next    = level_reg + LEVEL_W'(1);
                        speed_next    = (speed_reg >= SPEED_SAFE) ? (speed_reg - SPEED_STEPV)
                                                                  : SPEED_MIN;
                        // The schedule counts cleared levels instead of dividing the level number.
                        if (shrink_inc == SHR_LAST) begin
                            shrink_next = '0;
                            if (sched_reg > BLK_ONE) begin
                                sched_next = sched_reg - BLK_ONE;
                            end
                        end else begin
                            shrink_next = shrink_inc;
                        end
                        blocks_next = sched_next;
                        if ((CARRY_OVERLAP != 0) && (place_overlap < sched_next)) begin
                            blocks_next = place_overlap;
                        end
                    end
                end
            end
            WIN, OVER: begin
                if (go_rise) begin
                    state_next  = WAIT;
                    level_next  = LEVEL_FIRST;
                    speed_next  = SPEED_INIT;
                    blocks_next = BLK_INIT;
                    sched_next  = BLK_INIT;
                    shrink_next = '0;
                end
            end
            default: begin
                state_next = WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= WAIT;
            level_reg    <= LEVEL_FIRST;
            speed_reg    <= SPEED_INIT;
            blocks_reg   <= BLK_INIT;
            sched_reg    <= BLK_INIT;
            shrink_reg   <= '0;
            level_up_reg <= 1'b0;
            go_prev_reg  <= 1'b1;
            playing_reg  <= 1'b0;
            won_reg      <= 1'b0;
            over_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            speed_reg    <= speed_next;
            blocks_reg   <= blocks_next;
            sched_reg    <= sched_next;
            shrink_reg   <= shrink_next;
            level_up_reg <= level_up_next;
            go_prev_reg  <= go;
            // Status flags are registered copies of the upcoming state.
            playing_reg  <= (state_next == RUN);
            won_reg      <= (state_next == WIN);
            over_reg     <= (state_next == OVER);
        end
    end

    assign speed_count = speed_reg;
    assign num_blocks  = blocks_reg;
    assign curr_level  = level_reg;
    assign playing     = playing_reg;
    assign level_up    = level_up_reg;
    assign game_won    = won_reg;
    assign game_over   = over_reg;

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: a vector table of inputs and expected
// outputs, with expectations queued at drive time and popped after each edge.
module tb_level_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        go;
    logic        place_valid;
    logic        place_hit;
    logic [3:0]  place_overlap;

    logic [10:0] speed_count,   speed_count_c;
    logic [3:0]  num_blocks,    num_blocks_c;
    logic [5:0]  curr_level,    curr_level_c;
    logic        playing,       playing_c;
    logic        level_up,      level_up_c;
    logic        game_won,      game_won_c;
    logic        game_over,     game_over_c;

    always #5 clk = ~clk;

    level_sequencer dut (
        .clk(clk), .resetn(resetn), .go(go), .place_valid(place_valid),
        .place_hit(place_hit), .place_overlap(place_overlap),
        .speed_count(speed_count), .num_blocks(num_blocks), .curr_level(curr_level),
        .playing(playing), .level_up(level_up), .game_won(game_won), .game_over(game_over)
    );

    level_sequencer #(.CARRY_OVERLAP(1)) dut_c (
        .clk(clk), .resetn(resetn), .go(go), .place_valid(place_valid),
        .place_hit(place_hit), .place_overlap(place_overlap),
        .speed_count(speed_count_c), .num_blocks(num_blocks_c), .curr_level(curr_level_c),
        .playing(playing_c), .level_up(level_up_c), .game_won(game_won_c), .game_over(game_over_c)
    );

    typedef struct {
        string      nm;
        bit         rstn, gob, pv, hit;
        logic [3:0] ov;
        bit         sel;
        int         lvl, spd, blk;
        bit         ply, lu, won, ovr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int ref_speed(input int lvl);
        int s;
        s = 60 - 4 * (lvl - 1);
        return (s < 8) ? 8 : s;
    endfunction

    function automatic int ref_blocks(input int lvl);
        if (lvl <= 5)  return 3;
        if (lvl <= 10) return 2;
        return 1;
    endfunction

    task automatic add(input string nm, input bit r, input bit g, input bit pv, input bit hit,
                       input int ov, input bit sel, input int lvl, input int blk,
                       input bit ply, input bit lu, input bit won, input bit ovr);
        vec_t v;
        v.nm = nm; v.rstn = r; v.gob = g; v.pv = pv; v.hit = hit; v.ov = 4'(ov); v.sel = sel;
        v.lvl = lvl; v.spd = ref_speed(lvl); v.blk = blk;
        v.ply = ply; v.lu = lu; v.won = won; v.ovr = ovr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        resetn        = v.rstn;
        go            = v.gob;
        place_valid   = v.pv;
        place_hit     = v.hit;
        place_overlap = v.ov;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.sel) begin
            chk(e.nm, "curr_level",  int'(curr_level_c),  e.lvl);
            chk(e.nm, "speed_count", int'(speed_count_c), e.spd);
            chk(e.nm, "num_blocks",  int'(num_blocks_c),  e.blk);
            chk(e.nm, "playing",     int'(playing_c),     int'(e.ply));
            chk(e.nm, "level_up",    int'(level_up_c),    int'(e.lu));
            chk(e.nm, "game_won",    int'(game_won_c),    int'(e.won));
            chk(e.nm, "game_over",   int'(game_over_c),   int'(e.ovr));
        end else begin
            chk(e.nm, "curr_level",  int'(curr_level),  e.lvl);
            chk(e.nm, "speed_count", int'(speed_count), e.spd);
            chk(e.nm, "num_blocks",  int'(num_blocks),  e.blk);
            chk(e.nm, "playing",     int'(playing),     int'(e.ply));
            chk(e.nm, "level_up",    int'(level_up),    int'(e.lu));
            chk(e.nm, "game_won",    int'(game_won),    int'(e.won));
            chk(e.nm, "game_over",   int'(game_over),   int'(e.ovr));
        end
        $display("vec %-12s dut=%0d level=%0d speed=%0d blocks=%0d", e.nm, e.sel,
                 e.sel ? curr_level_c : curr_level, e.sel ? speed_count_c : speed_count,
                 e.sel ? num_blocks_c : num_blocks);
    endtask

    initial begin
        resetn = 1'b0; go = 1'b1; place_valid = 1'b0; place_hit = 1'b0; place_overlap = '0;

        // Go held through reset must not start a game.
        add("reset",       0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add("hold_go",     1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add("hold_go2",    1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add("release",     1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add("start",       1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);

        // Clear levels 1..14, pressing go between levels.
        for (int l = 1; l <= 14; l++) begin
            add("hit",     1, 0, 1, 1, 3, 0, l + 1, ref_blocks(l + 1), 0, 1, 0, 0);
            add("resume",  1, 1, 0, 0, 0, 0, l + 1, ref_blocks(l + 1), 1, 0, 0, 0);
        end

        add("win",         1, 0, 1, 1, 3, 0, 15, 1, 0, 0, 1, 0);
        add("win_hold",    1, 0, 0, 0, 0, 0, 15, 1, 0, 0, 1, 0);
        add("restart_win", 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add("idle",        1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);

        // Reach level 4 then miss.
        add("start4",      1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
        for (int l = 1; l <= 3; l++) begin
            add("hit4",    1, 0, 1, 1, 3, 0, l + 1, 3, 0, 1, 0, 0);
            add("resume4", 1, 1, 0, 0, 0, 0, l + 1, 3, 1, 0, 0, 0);
        end
        add("miss",        1, 0, 1, 0, 3, 0, 4, 3, 0, 0, 0, 1);
        add("pv_in_over",  1, 0, 1, 1, 3, 0, 4, 3, 0, 0, 0, 1);
        add("restart_ovr", 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add("idle2",       1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);

        // place_valid on the go edge is ignored, then climb to level 7 and reset.
        add("pv_on_go",    1, 1, 1, 1, 3, 0, 1, 3, 1, 0, 0, 0);
        for (int l = 1; l <= 6; l++) begin
            add("hit7",    1, 0, 1, 1, 3, 0, l + 1, ref_blocks(l + 1), 0, 1, 0, 0);
            add("resume7", 1, 1, 0, 0, 0, 0, l + 1, ref_blocks(l + 1), 1, 0, 0, 0);
        end
        add("mid_reset",   0, 0, 1, 1, 3, 0, 1, 3, 0, 0, 0, 0);
        add("post_reset",  1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);

        // Overlap-carrying instance.
        add("c_start",     1, 1, 0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
        add("c_ov2",       1, 0, 1, 1, 2, 1, 2, 2, 0, 1, 0, 0);
        add("c_resume",    1, 1, 0, 0, 0, 1, 2, 2, 1, 0, 0, 0);
        add("c_ov0",       1, 0, 1, 1, 0, 1, 2, 2, 0, 0, 0, 1);
        add("c_restart",   1, 1, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0);
        add("c_idle",      1, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0);
        add("c_start2",    1, 1, 0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
        add("c_ov7",       1, 0, 1, 1, 7, 1, 2, 3, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
